digit_sprite_ctrl: RTL
======================

Name: digit_sprite_ctrl

Overview:
Sequences a single shared digit-sprite ROM (glyphs 0-9 stacked, 2-bit palette index per pixel) to draw a NUM_DIGITS-wide decimal number at a fixed screen position. It accepts a binary value through a valid/ready handshake and converts it to BCD with a multi-cycle double-dabble FSM. Digits are committed at vertical blank so no frame tears. Per pixel, it generates the ROM address and a pipeline-aligned opaque flag for the downstream palette/compositor.

Parameters:
NUM_DIGITS, 4, number of decimal digits displayed (1-6)
VAL_W, 14, width of binary input value
DIGIT_W, 50, glyph width in pixels
DIGIT_H, 50, glyph height in pixels
ORIGIN_X, 400, left edge of digit 0 (most significant)
ORIGIN_Y, 16, top edge of all digits
LZB, 1, 1 = suppress leading zeros (least significant digit always drawn)

Ports:
vga_clk  in  1  pixel clock; all logic on posedge
reset  in  1  synchronous, active-high
DrawX  in  10  current pixel column; increments by 1 per vga_clk within a line
DrawY  in  10  current pixel row
blank  in  1  1 = active video (codebase polarity)
value  in  VAL_W  binary number to display
value_valid  in  1  value offered
value_ready  out  1  controller can accept value
rom_address  out  15  glyph ROM address, registered
rom_q  in  2  ROM data; valid one vga_clk after rom_address (ROM clocked on negedge)
pixel_on  out  1  current pipelined pixel belongs to a drawn, non-transparent glyph pixel
busy  out  1  conversion in progress or committed-digit update pending

Behaviour:
- Reset: value_ready=1, busy=0, rom_address=0, pixel_on=0, FSM=IDLE, shadow and live BCD = all zero (displays "0").
- FSM states:
  - IDLE: value_ready=1. On value_valid, latch value, clear BCD scratch, set bit counter=VAL_W, and go to SHIFT.
  - SHIFT: one double-dabble iteration per cycle: add 3 to each nibble >=5, then shift left one bit. Run exactly VAL_W cycles, then go to CHECK.
  - CHECK: one cycle. If the latched value > 10^NUM_DIGITS-1, shadow = all 9s (saturate); else shadow = BCD. Go to PEND.
  - PEND: wait for frame commit: first cycle with DrawY==480 and DrawX==0. Then live digits <= shadow, return to IDLE.
- value_ready=1 only in IDLE. busy=1 in SHIFT/CHECK/PEND. Handshake transfers on value_valid & value_ready. value_valid while not ready is ignored; there is no queueing.
- Conversion latency from accept to PEND is VAL_W+1 cycles.
- Live digits change only at commit. A reset mid-conversion discards the value and displays 0.
- Pixel pipeline, latency 2 from DrawX/DrawY to pixel_on:
  - Stage 1 (registered): box hit = ORIGIN_X <= DrawX < ORIGIN_X+NUM_DIGITS*DIGIT_W and ORIGIN_Y <= DrawY < ORIGIN_Y+DIGIT_H, and blank=1.
  - Column counter x_off and slot counter slot:
    - Both reset to 0 when DrawX==ORIGIN_X.
    - x_off increments each cycle in the box and wraps DIGIT_W-1 -> 0 with slot+1.
  - row_base:
    - Cleared when DrawY==ORIGIN_Y at DrawX==0.
    - Increases by DIGIT_W at DrawX==0 of each subsequent row inside the box.
  - No dividers or general multipliers are used; digit*DIGIT_W*DIGIT_H comes from a 10-entry constant table.
  - rom_address <= digit_base[live_digit[slot]] + row_base + x_off. Outside the box it holds 0.
  - Stage 2: pixel_on <= hit_d1 & ~suppressed_d1 & (rom_q != 0). Palette index 0 is transparent.
- Leading-zero suppression (LZB=1): slot i is suppressed iff all of digits 0..i are zero and i < NUM_DIGITS-1.
- The arithmetic width of rom_address must hold 10*DIGIT_W*DIGIT_H-1. Elaboration errors if it exceeds 15 bits.
- DrawX jumping out of the box mid-line (hsync) clears the hit flag. Counters resume correctly on the next line.

Test Plan:
- Reset, then scan a frame -> live digits 0000. With LZB=1, only slot 3 draws. rom_address at (ORIGIN_X+150, ORIGIN_Y) = 0; pixel_on follows rom_q!=0 two cycles later.
- Send value=1234 while IDLE -> value_ready drops the next cycle and busy=1 for 15 cycles plus the wait for commit. Display is unchanged until DrawY=480/DrawX=0, then reads 1234.
- value=16383 -> saturates to 9999. At (ORIGIN_X+0, ORIGIN_Y+1), rom_address = 9*2500+50 = 22550.
- value=7 -> slots 0-2 give pixel_on=0 even with rom_q=3. Slot 3 draws glyph 7: address at (ORIGIN_X+170, ORIGIN_Y+2) = 17500+100+20 = 17620.
- Assert value_valid with 42 during SHIFT of a prior value -> 42 is ignored, the prior value is displayed. Assert reset during PEND -> display 0, value_ready=1 the cycle after reset deasserts.
- Set blank=0 inside the box -> pixel_on=0 two cycles later, regardless of rom_q.

Source files
------------

// File: rtl/digit_sprite_ctrl.sv
// Decimal number sprite sequencer: binary-to-BCD conversion, frame-synchronous
// digit commit and a two-stage glyph ROM address / opacity pipeline.
module digit_sprite_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int VAL_W      = 14,
    parameter int DIGIT_W    = 50,
    parameter int DIGIT_H    = 50,
    parameter int ORIGIN_X   = 400,
    parameter int ORIGIN_Y   = 16,
    parameter int LZB        = 1
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    input  logic             blank,
    input  logic [VAL_W-1:0] value,
    input  logic             value_valid,
    output logic             value_ready,
    output logic [14:0]      rom_address,
    input  logic [1:0]       rom_q,
    output logic             pixel_on,
    output logic             busy
);

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int BW    = 4 * NUM_DIGITS;
    localparam int CW    = $clog2(VAL_W + 1);
    localparam int XW    = $clog2(DIGIT_W + 1);
    localparam int SW    = $clog2(NUM_DIGITS + 1);
    localparam int GLYPH = DIGIT_W * DIGIT_H;

    localparam logic [31:0] MAX_VAL = 32'(pow10(NUM_DIGITS) - 1);
    localparam logic [BW-1:0] ALL9  = {NUM_DIGITS{4'h9}};

    localparam logic [10:0] X_LO = 11'(ORIGIN_X);
    localparam logic [10:0] X_HI = 11'(ORIGIN_X + NUM_DIGITS * DIGIT_W);
    localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
    localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + DIGIT_H);
    localparam logic [9:0]  X0   = 10'(ORIGIN_X);
    localparam logic [9:0]  Y0   = 10'(ORIGIN_Y);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_PEND  = 2'd3;

    if (10 * GLYPH - 1 > 32767) begin : g_addr_chk
        $error("digit_sprite_ctrl: glyph ROM does not fit a 15-bit address");
    end

    if (NUM_DIGITS < 1 || NUM_DIGITS > 6) begin : g_digit_chk
        $error("digit_sprite_ctrl: NUM_DIGITS must be 1..6");
    end

    // Start address of each stacked glyph, folded to constants.
    function automatic logic [14:0] digit_base(input logic [3:0] d);
        unique case (d)
            4'd0:    return 15'd0;
            4'd1:    return 15'(GLYPH * 1);
            4'd2:    return 15'(GLYPH * 2);
            4'd3:    return 15'(GLYPH * 3);
            4'd4:    return 15'(GLYPH * 4);
            4'd5:    return 15'(GLYPH * 5);
            4'd6:    return 15'(GLYPH * 6);
            4'd7:    return 15'(GLYPH * 7);
            4'd8:    return 15'(GLYPH * 8);
            4'd9:    return 15'(GLYPH * 9);
            default: return 15'd0;
        endcase
    endfunction

    logic [1:0]       state;
    logic [VAL_W-1:0] latched;
    logic [VAL_W-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    scratch;
    logic [BW-1:0]    adj;
    logic [BW-1:0]    shadow;
    logic [BW-1:0]    live;
    logic             commit;

    assign value_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign commit      = (DrawY == 10'd480) && (DrawX == 10'd0);

    always_comb begin
        adj = scratch;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state   <= S_IDLE;
            latched <= '0;
            shreg   <= '0;
            cnt     <= '0;
            scratch <= '0;
            shadow  <= '0;
            live    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (value_valid) begin
                        latched <= value;
                        shreg   <= value;
                        scratch <= '0;
                        cnt     <= CW'(VAL_W);
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    scratch <= {adj[BW-2:0], shreg[VAL_W-1]};
                    shreg   <= shreg << 1;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= S_CHECK;
                end
                S_CHECK: begin
                    shadow <= (32'(latched) > MAX_VAL) ? ALL9 : scratch;
                    state  <= S_PEND;
                end
                S_PEND: begin
                    if (commit) begin
                        live  <= shadow;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [XW-1:0]         x_off;
    logic [SW-1:0]         slot;
    logic [14:0]           row_base;
    logic                  hit_d1;
    logic                  supp_d1;
    logic                  in_x;
    logic                  in_y;
    logic                  in_box;
    logic                  col_start;
    logic [XW-1:0]         x_cur;
    logic [SW-1:0]         slot_cur;
    logic [3:0]            cur_digit;
    logic                  cur_supp;
    logic [NUM_DIGITS-1:0] supp;

    assign in_x      = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI);
    assign in_y      = ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);
    assign in_box    = in_x && in_y;
    assign col_start = (DrawX == X0);
    assign x_cur     = col_start ? '0 : x_off;
    assign slot_cur  = col_start ? '0 : slot;

    // Slot 0 is the most significant digit; the last slot is never blanked.
    always_comb begin : lz_blank
        logic all_zero;
        all_zero = 1'b1;
        supp     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            all_zero = all_zero && (live[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
            supp[i]  = (LZB != 0) && (i < NUM_DIGITS - 1) && all_zero;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_supp  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot_cur == SW'(i)) begin
                cur_digit = live[4*(NUM_DIGITS-1-i) +: 4];
                cur_supp  = supp[i];
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            x_off       <= '0;
            slot        <= '0;
            row_base    <= '0;
            hit_d1      <= 1'b0;
            supp_d1     <= 1'b0;
            rom_address <= '0;
            pixel_on    <= 1'b0;
        end else begin
            hit_d1   <= in_box && blank;
            supp_d1  <= cur_supp;
            pixel_on <= hit_d1 && !supp_d1 && (rom_q != 2'd0);

            if (in_box) begin
                rom_address <= digit_base(cur_digit) + row_base + 15'(x_cur);
            end else begin
                rom_address <= '0;
            end

            if (in_box) begin
                if (x_cur == XW'(DIGIT_W - 1)) begin
                    x_off <= '0;
                    slot  <= slot_cur + SW'(1);
                end else begin
                    x_off <= x_cur + XW'(1);
                    slot  <= slot_cur;
                end
            end else begin
                x_off <= x_cur;
                slot  <= slot_cur;
            end

            if (DrawX == 10'd0) begin
                if (DrawY == Y0) begin
                    row_base <= '0;
                end else if (in_y) begin
                    row_base <= row_base + 15'(DIGIT_W);
                end
            end
        end
    end

endmodule
